// File: rtl/scr1_tcm_portb_arbiter.sv
// scr1_tcm_portb_arbiter: shares TCM port B between the core data path (m0) and the debug/loader DMA (m1)
module scr1_tcm_portb_arbiter #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_NBYTES = 4,
  parameter int SCR1_AWIDTH = 16,
  parameter int STARVE_MAX  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [SCR1_NBYTES-1:0]   m0_be,
  input  logic [SCR1_AWIDTH-1:0]   m0_addr,
  input  logic [SCR1_WIDTH-1:0]    m0_wdata,
  output logic                     m0_ack,
  output logic                     m0_rvalid,
  output logic [SCR1_WIDTH-1:0]    m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [SCR1_NBYTES-1:0]   m1_be,
  input  logic [SCR1_AWIDTH-1:0]   m1_addr,
  input  logic [SCR1_WIDTH-1:0]    m1_wdata,
  output logic                     m1_ack,
  output logic                     m1_rvalid,
  output logic [SCR1_WIDTH-1:0]    m1_rdata,
  output logic                     mem_renb,
  output logic                     mem_wenb,
  output logic [SCR1_NBYTES-1:0]   mem_webb,
  output logic [SCR1_AWIDTH-3:0]   mem_addrb,
  output logic [SCR1_WIDTH-1:0]    mem_datab,
  input  logic [SCR1_WIDTH-1:0]    mem_qb
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  logic       resp_pend, resp_owner, resp_is_rd;
  logic       grant0, grant1;
  logic       unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};
  // m1 wins when m0 is idle or once it has lost STARVE_MAX cycles in a row
  assign grant1 = ~rst & m1_req & (~m0_req | starve_cnt == SMAX);
  assign grant0 = ~rst & m0_req & ~grant1;
  assign m0_ack = grant0;
  assign m1_ack = grant1;
  assign mem_renb  = (grant0 & ~m0_we) | (grant1 & ~m1_we);
  assign mem_wenb  = (grant0 & m0_we) | (grant1 & m1_we);
  assign mem_webb  = grant1 ? m1_be : m0_be;
  assign mem_addrb = grant1 ? m1_addr[SCR1_AWIDTH-1:2] : m0_addr[SCR1_AWIDTH-1:2];
  assign mem_datab = grant1 ? m1_wdata : m0_wdata;
  assign m0_rvalid = resp_pend & ~resp_owner;
  assign m1_rvalid = resp_pend & resp_owner;
  assign m0_rdata  = resp_is_rd ? mem_qb : '0;
  assign m1_rdata  = resp_is_rd ? mem_qb : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
      resp_is_rd <= 1'b0;
    end else begin
      starve_cnt <= (m1_req & grant0) ? (starve_cnt == SMAX ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
      resp_pend  <= grant0 | grant1;
      resp_owner <= grant1;
      resp_is_rd <= grant1 ? ~m1_we : ~m0_we;
    end
  end
endmodule

// File: tb/tb_scr1_tcm_portb_arbiter.sv
// tb_scr1_tcm_portb_arbiter: directed checks of the port B arbiter against a behavioural TCM port
module tb_scr1_tcm_portb_arbiter;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic m0_ack, m0_rvalid, m1_ack, m1_rvalid, mem_renb, mem_wenb;
  logic [31:0] m0_rdata, m1_rdata, mem_datab, mem_qb;
  logic [3:0] mem_webb;
  logic [13:0] mem_addrb;
  logic [31:0] mem [0:63];
  int errors = 0, checks = 0;
  logic exp_r0, exp_r1;

  scr1_tcm_portb_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_renb(mem_renb), .mem_wenb(mem_wenb), .mem_webb(mem_webb), .mem_addrb(mem_addrb),
    .mem_datab(mem_datab), .mem_qb(mem_qb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wenb)
      for (int b = 0; b < 4; b++)
        if (mem_webb[b]) mem[mem_addrb[5:0]][b*8 +: 8] <= mem_datab[b*8 +: 8];
    if (mem_renb) mem_qb <= mem[mem_addrb[5:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_req = 0;
    m1_req = 0;
  endtask

  task automatic m0_cmd(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic m1_cmd(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_qb = '0;
    // reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_en", {mem_renb, mem_wenb}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    nxt;
    rst = 0;
    @(negedge clk);
    chk("idle_outs", {m0_ack, m1_ack, m0_rvalid, m1_rvalid, mem_renb, mem_wenb}, 0);
    chk("idle_starve", dut.starve_cnt, 0);
    // m0 write then read
    nxt;
    m0_cmd(1, 16'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("m0w_ack", {m0_ack, m1_ack}, 2'b10);
    chk("m0w_en", {mem_wenb, mem_renb}, 2'b10);
    chk("m0w_addr", mem_addrb, 14'h004);
    chk("m0w_webb", mem_webb, 4'hF);
    chk("m0w_data", mem_datab, 32'hDEADBEEF);
    nxt;
    m0_cmd(0, 16'h0010, 0, 4'hF);
    @(negedge clk);
    chk("m0r_ack", m0_ack, 1);
    chk("m0r_en", {mem_wenb, mem_renb}, 2'b01);
    chk("m0w_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("m0w_rdata", m0_rdata, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("m0r_rvalid", {m0_rvalid, m1_rvalid, m0_ack}, 3'b100);
    chk("m0r_rdata", m0_rdata, 32'hDEADBEEF);
    // m1 partial write then read
    nxt;
    m1_cmd(1, 16'h0010, 32'h11223344, 4'b0010);
    @(negedge clk);
    chk("m1w_ack", {m0_ack, m1_ack}, 2'b01);
    chk("m1w_webb", mem_webb, 4'b0010);
    nxt;
    m1_cmd(0, 16'h0010, 0, 4'h0);
    @(negedge clk);
    chk("m1r_ack", m1_ack, 1);
    chk("m1w_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    nxt;
    idle;
    @(negedge clk);
    chk("m1r_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("m1r_rdata", m1_rdata, 32'hDEAD33EF);
    // both requesting: 4 m0 grants then one forced m1 grant, repeating
    nxt;
    m0_cmd(0, 16'h0010, 0, 4'hF);
    m1_cmd(0, 16'h0020, 0, 4'hF);
    exp_r0 = 0;
    exp_r1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_ack%0d", k), {m0_ack, m1_ack}, (k % 5 == 4) ? 2'b01 : 2'b10);
      chk($sformatf("starve_rv%0d", k), {m0_rvalid, m1_rvalid}, {exp_r0, exp_r1});
      if (exp_r0) chk($sformatf("starve_rd%0d", k), m0_rdata, 32'hDEAD33EF);
      if (exp_r1) chk($sformatf("starve_rd%0d", k), m1_rdata, 32'h0);
      exp_r0 = (k % 5 != 4);
      exp_r1 = (k % 5 == 4);
      nxt;
    end
    idle;
    @(negedge clk);
    chk("starve_tail", {m0_rvalid, m1_rvalid, m0_ack, m1_ack}, 4'b0100);
    // reset during a pending m1 read drops the completion
    nxt;
    m1_cmd(0, 16'h0010, 0, 4'h0);
    @(negedge clk);
    chk("rstmid_ack", m1_ack, 1);
    nxt;
    idle;
    rst = 1;
    @(negedge clk);
    chk("rstmid_rv", {m0_rvalid, m1_rvalid}, 0);
    nxt;
    rst = 0;
    @(negedge clk);
    chk("rstmid_rv2", {m0_rvalid, m1_rvalid}, 0);
    nxt;
    m1_cmd(0, 16'h0010, 0, 4'h0);
    @(negedge clk);
    chk("rstmid_reack", m1_ack, 1);
    chk("rstmid_rv3", m1_rvalid, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("rstmid_rv4", m1_rvalid, 1);
    chk("rstmid_rdata", m1_rdata, 32'hDEAD33EF);
    // m0 read completes while a be=0 m1 write is accepted
    nxt;
    m0_cmd(0, 16'h0010, 0, 4'hF);
    @(negedge clk);
    chk("b2b_ack0", m0_ack, 1);
    nxt;
    idle;
    m1_cmd(1, 16'h0010, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    chk("b2b_same", {m0_rvalid, m1_ack, m1_rvalid}, 3'b110);
    chk("b2b_rd0", m0_rdata, 32'hDEAD33EF);
    chk("b2b_be0", {mem_wenb, mem_webb}, 5'b10000);
    nxt;
    idle;
    @(negedge clk);
    chk("b2b_rv1", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("b2b_rd1", m1_rdata, 0);
    nxt;
    m0_cmd(0, 16'h0010, 0, 4'hF);
    nxt;
    idle;
    @(negedge clk);
    chk("be0_keep", m0_rdata, 32'hDEAD33EF);
    nxt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
